uart_tx_fifo_reader: RTL

//  Read side of the UART TX FIFO. Pops bytes from the 128x8 sync FIFO and serialises each
//  as an async frame on tx: start bit, 7/8 data bits LSB first, optional parity, 1 stop bit.

---
 rtl/uart_tx_fifo_reader.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
// Read side of the UART TX FIFO. Pops one byte at a time and sends it on tx as
// an async frame: start bit, 7 or 8 data bits LSB first, optional parity bit,
// one stop bit. Each serial bit lasts OVERSAMPLE baud_en ticks.
// Outputs are driven straight from registers.

module uart_tx_fifo_reader #(
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       baud_en,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_read_n,
   output logic       tx,
   output logic       tx_busy
);

   localparam int unsigned      TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [1:0]        WAIT_LAST = 2'(RD_LATENCY - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POP,
      ST_WAIT,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t            state_q,   state_d;
   logic [TICK_W-1:0] tick_q,    tick_d;
   logic [1:0]        wait_q,    wait_d;
   logic [2:0]        bit_q,     bit_d;
   logic [7:0]        shift_q,   shift_d;
   logic              bit8_q,    bit8_d;
   logic              par_en_q,  par_en_d;
   logic              par_bit_q, par_bit_d;
   logic              tx_q,      tx_d;
   logic              rd_n_q,    rd_n_d;
   logic              busy_q,    busy_d;

   logic              bit_end;
   logic [2:0]        last_bit;
   logic [7:0]        data_sent;
   logic              serialising;

   assign bit_end     = baud_en && (tick_q == TICK_LAST);
   assign last_bit    = bit8_q ? 3'd7 : 3'd6;
   assign data_sent   = bit8 ? fifo_data : {1'b0, fifo_data[6:0]};
   assign serialising = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_PARITY) || (state_q == ST_STOP);

   // Next-state and registered-output values for the frame sequencer
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      wait_d    = wait_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      bit8_d    = bit8_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      tx_d      = tx_q;
      rd_n_d    = rd_n_q;
      busy_d    = busy_q;

      if (serialising && baud_en) begin
         tick_d = bit_end ? '0 : tick_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            tick_d = '0;
            tx_d   = 1'b1;
            if (!fifo_empty) begin
               state_d = ST_POP;
               rd_n_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end

         ST_POP: begin
            rd_n_d  = 1'b1;
            wait_d  = '0;
            tick_d  = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            tick_d = '0;
            if (wait_q == WAIT_LAST) begin
               // Byte and line configuration are captured together so the
               // whole frame uses one consistent setting.
               shift_d   = fifo_data;
               bit8_d    = bit8;
               par_en_d  = parity_en;
               par_bit_d = (^data_sent) ^ odd_n_even;
               tx_d      = 1'b0;
               state_d   = ST_START;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end

         ST_START: begin
            if (bit_end) begin
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == last_bit) begin
                  if (par_en_q) begin
                     tx_d    = par_bit_q;
                     state_d = ST_PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = ST_STOP;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end
         end

         ST_PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = ST_STOP;
            end
         end

         ST_STOP: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            tx_d    = 1'b1;
            rd_n_d  = 1'b1;
            busy_d  = 1'b0;
            tick_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         tick_q    <= '0;
         wait_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         bit8_q    <= 1'b0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_q      <= 1'b1;
         rd_n_q    <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         wait_q    <= wait_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         bit8_q    <= bit8_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         tx_q      <= tx_d;
         rd_n_q    <= rd_n_d;
         busy_q    <= busy_d;
      end
   end

   assign tx          = tx_q;
   assign fifo_read_n = rd_n_q;
   assign tx_busy     = busy_q;

endmodule
